// File: rtl/norm_shift_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | norm_shift_ctrl: normalization shift controller ahead of the barrel      |
// | shifter. Optional macro NORM_DENORM_CLAMP_EN clamps underflow shifts.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module norm_shift_ctrl #(
  parameter int SWR = 26,
  parameter int EW  = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_i,
  input  logic [SWR-1:0] Add_Result_i,
  input  logic           Carry_i,
  input  logic [EW-1:0]  Exp_i,
  output logic [EW-1:0]  Shift_Value_o,
  output logic           Left_Right_o,
  output logic           Bit_Shift_o,
  output logic           load_o,
  output logic [EW-1:0]  Exp_o,
  output logic           Zero_o,
  output logic           Underflow_o,
  output logic           Overflow_o,
  output logic           busy_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DETECT = 2'd1,
    ISSUE  = 2'd2
  } state_t;

  state_t         state;
  logic [SWR-1:0] sum_q;
  logic           carry_q;
  logic [EW-1:0]  exp_q;
  logic [EW-1:0]  lz_q;
  logic [EW-1:0]  exp_inc;

  // Highest set bit wins; an all-zero input yields SWR.
  function automatic logic [EW-1:0] lzc(input logic [SWR-1:0] v);
    lzc = EW'(SWR);
    for (int i = 0; i < SWR; i++) begin
      if (v[i]) lzc = EW'(SWR - 1 - i);
    end
  endfunction

  assign exp_inc = exp_q + EW'(1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      sum_q         <= '0;
      carry_q       <= 1'b0;
      exp_q         <= '0;
      lz_q          <= '0;
      Shift_Value_o <= '0;
      Left_Right_o  <= 1'b0;
      Bit_Shift_o   <= 1'b0;
      load_o        <= 1'b0;
      Exp_o         <= '0;
      Zero_o        <= 1'b0;
      Underflow_o   <= 1'b0;
      Overflow_o    <= 1'b0;
      busy_o        <= 1'b0;
    end else begin
      load_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            sum_q   <= Add_Result_i;
            carry_q <= Carry_i;
            exp_q   <= Exp_i;
            busy_o  <= 1'b1;
            state   <= DETECT;
          end
        end
        DETECT: begin
          lz_q  <= lzc(sum_q);
          state <= ISSUE;
        end
        ISSUE: begin
          load_o      <= 1'b1;
          busy_o      <= 1'b0;
          state       <= IDLE;
          Zero_o      <= 1'b0;
          Underflow_o <= 1'b0;
          Overflow_o  <= 1'b0;
          Bit_Shift_o <= 1'b0;
          if (carry_q) begin
            Left_Right_o  <= 1'b0;
            Shift_Value_o <= EW'(1);
            Bit_Shift_o   <= 1'b1;
            Exp_o         <= exp_inc;
            Overflow_o    <= (exp_inc == '1) || (exp_q == '1);
          end else if (sum_q == '0) begin
            Zero_o        <= 1'b1;
            Left_Right_o  <= 1'b1;
            Shift_Value_o <= '0;
            Exp_o         <= '0;
          end else if (lz_q < exp_q) begin
            Left_Right_o  <= 1'b1;
            Shift_Value_o <= lz_q;
            Exp_o         <= exp_q - lz_q;
          end else begin
            Left_Right_o  <= 1'b1;
            Underflow_o   <= 1'b1;
            Exp_o         <= '0;
`ifdef NORM_DENORM_CLAMP_EN
            // Stop one short so the value lands as a subnormal.
            Shift_Value_o <= (exp_q != '0) ? (exp_q - EW'(1)) : '0;
`else
            Shift_Value_o <= lz_q;
`endif
          end
        end
        default: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
